// File: rtl/cache_types_pkg.sv
// Shared cacheline/burst geometry and the adaptor state encoding.
package cache_types_pkg;

   localparam int unsigned LINE_WIDTH  = 256;
   localparam int unsigned BURST_WIDTH = 64;
   localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned OFFSET_BITS = 5;

   typedef logic [LINE_WIDTH-1:0]  cacheline_t;
   typedef logic [BURST_WIDTH-1:0] burst_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges single-transfer cacheline requests to 4-beat memory bursts and
// reports completion with a one-cycle resp_o pulse.
module cacheline_adaptor #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BURST_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   import cache_types_pkg::adaptor_state_t;
   import cache_types_pkg::IDLE;
   import cache_types_pkg::RD;
   import cache_types_pkg::WR;
   import cache_types_pkg::DONE;
   import cache_types_pkg::OFFSET_BITS;

   localparam int unsigned BEATS  = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   adaptor_state_t          state_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LINE_WIDTH-1:0]   buf_q;
   logic [ADDR_WIDTH-1:0]   aligned_addr;

   assign aligned_addr = {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // read wins when both requests are raised together
               if (read_i) begin
                  addr_q  <= aligned_addr;
                  beat_q  <= '0;
                  state_q <= RD;
               end else if (write_i) begin
                  addr_q  <= aligned_addr;
                  buf_q   <= line_i;
                  beat_q  <= '0;
                  state_q <= WR;
               end
            end
            RD: begin
               if (resp_i) begin
                  buf_q[int'(beat_q) * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) state_q <= DONE;
               end
            end
            WR: begin
               if (resp_i) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign read_o    = (state_q == RD);
   assign write_o   = (state_q == WR);
   assign resp_o    = (state_q == DONE);
   assign address_o = addr_q;
   assign line_o    = buf_q;
   assign burst_o   = buf_q[int'(beat_q) * BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized transactions against a line-level memory/arbiter model.
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   logic [255:0] model_line = '0;

   cacheline_adaptor #(
      .LINE_WIDTH (256),
      .BURST_WIDTH(64),
      .ADDR_WIDTH (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .line_i   (line_i),
      .line_o   (line_o),
      .address_i(address_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .resp_o   (resp_o),
      .burst_i  (burst_i),
      .burst_o  (burst_o),
      .address_o(address_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .resp_i   (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand64(), rand64(), rand64(), rand64()};
   endfunction

   // Read: request, memory supplies beats b[k] after gaps[k] idle cycles each.
   task automatic do_read(input logic [31:0] addr, input logic [63:0] b[4],
                          input int unsigned gaps[4], input logic also_write);
      logic [255:0] exp_line;
      logic [31:0]  exp_addr;
      exp_addr = addr & ~32'h1F;
      exp_line = '0;
      read_i = 1'b1; write_i = also_write; address_i = addr; line_i = rand256(); resp_i = 1'b0;
      tick();
      chk("rd_read_o_rise", 256'(read_o), 256'(1'b1));
      chk("rd_write_o_low", 256'(write_o), 256'(1'b0));
      chk("rd_address_o", 256'(address_o), 256'(exp_addr));
      for (int k = 0; k < 4; k++) begin
         for (int unsigned g = 0; g < gaps[k]; g++) begin
            resp_i = 1'b0; burst_i = rand64(); address_i = $urandom();
            tick();
            chk("rd_stall_read_o", 256'(read_o), 256'(1'b1));
            chk("rd_stall_resp_o", 256'(resp_o), 256'(1'b0));
         end
         resp_i = 1'b1; burst_i = b[k];
         exp_line = exp_line | (256'(b[k]) << (64 * k));
         tick();
         if (k < 3) begin
            chk("rd_beat_read_o", 256'(read_o), 256'(1'b1));
            chk("rd_beat_resp_o", 256'(resp_o), 256'(1'b0));
            chk("rd_addr_hold", 256'(address_o), 256'(exp_addr));
         end else begin
            chk("rd_resp_o", 256'(resp_o), 256'(1'b1));
            chk("rd_done_read_o", 256'(read_o), 256'(1'b0));
            chk("rd_done_write_o", 256'(write_o), 256'(1'b0));
            chk("rd_line_o", line_o, exp_line);
         end
      end
      // requests still high and stray resp_i during the pulse must be ignored
      resp_i = 1'($urandom());
      tick();
      chk("rd_resp_pulse_end", 256'(resp_o), 256'(1'b0));
      chk("rd_after_read_o", 256'(read_o), 256'(1'b0));
      chk("rd_after_write_o", 256'(write_o), 256'(1'b0));
      chk("rd_line_stable", line_o, exp_line);
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      model_line = exp_line;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input int unsigned gaps[4]);
      logic [31:0] exp_addr;
      exp_addr = addr & ~32'h1F;
      write_i = 1'b1; read_i = 1'b0; address_i = addr; line_i = line; resp_i = 1'b0;
      tick();
      chk("wr_write_o_rise", 256'(write_o), 256'(1'b1));
      chk("wr_read_o_low", 256'(read_o), 256'(1'b0));
      chk("wr_address_o", 256'(address_o), 256'(exp_addr));
      line_i = rand256(); address_i = $urandom();
      for (int k = 0; k < 4; k++) begin
         chk("wr_burst_o", 256'(burst_o), 256'(line[64*k +: 64]));
         for (int unsigned g = 0; g < gaps[k]; g++) begin
            resp_i = 1'b0;
            tick();
            chk("wr_stall_write_o", 256'(write_o), 256'(1'b1));
            chk("wr_stall_burst_o", 256'(burst_o), 256'(line[64*k +: 64]));
         end
         resp_i = 1'b1;
         tick();
         if (k < 3) begin
            chk("wr_beat_write_o", 256'(write_o), 256'(1'b1));
            chk("wr_beat_resp_o", 256'(resp_o), 256'(1'b0));
         end else begin
            chk("wr_resp_o", 256'(resp_o), 256'(1'b1));
            chk("wr_done_write_o", 256'(write_o), 256'(1'b0));
         end
      end
      resp_i = 1'($urandom());
      tick();
      chk("wr_resp_pulse_end", 256'(resp_o), 256'(1'b0));
      chk("wr_after_write_o", 256'(write_o), 256'(1'b0));
      chk("wr_line_o_latched", line_o, line);
      write_i = 1'b0; resp_i = 1'b0;
      model_line = line;
   endtask

   task automatic idle_cycles(input int unsigned n);
      read_i = 1'b0; write_i = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         resp_i = 1'($urandom()); burst_i = rand64();
         tick();
         chk("idle_read_o", 256'(read_o), 256'(1'b0));
         chk("idle_write_o", 256'(write_o), 256'(1'b0));
         chk("idle_resp_o", 256'(resp_o), 256'(1'b0));
         chk("idle_line_o", line_o, model_line);
      end
      resp_i = 1'b0;
   endtask

   initial begin
      logic [63:0]  b[4];
      int unsigned  g[4];
      logic [255:0] wl;

      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      address_i = '0; line_i = '0; burst_i = '0;
      tick(); tick();
      chk("rst_read_o", 256'(read_o), 256'(1'b0));
      chk("rst_write_o", 256'(write_o), 256'(1'b0));
      chk("rst_resp_o", 256'(resp_o), 256'(1'b0));
      chk("rst_line_o", line_o, 256'(0));
      chk("rst_burst_o", 256'(burst_o), 256'(0));
      chk("rst_address_o", 256'(address_o), 256'(0));
      rst = 1'b0;
      idle_cycles(2);

      // zero-wait read
      b = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      g = '{0, 0, 0, 0};
      do_read(32'h0000_1234, b, g, 1'b0);
      idle_cycles(1);

      // write with the canonical four-word line
      wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      do_write(32'h8000_003F, wl, g);
      idle_cycles(1);

      // stalled read, resp_i = 1,0,0,1,1,0,1
      for (int k = 0; k < 4; k++) b[k] = rand64();
      g = '{0, 2, 0, 1};
      do_read(32'h0000_4567, b, g, 1'b0);
      idle_cycles(1);

      // read and write together: read wins
      for (int k = 0; k < 4; k++) b[k] = rand64();
      g = '{0, 1, 0, 0};
      do_read(32'h1234_5678, b, g, 1'b1);
      idle_cycles(2);

      // reset after two read beats discards the partial line
      read_i = 1'b1; address_i = 32'hCAFE_0040; resp_i = 1'b0;
      tick();
      chk("rstmid_read_o", 256'(read_o), 256'(1'b1));
      for (int k = 0; k < 2; k++) begin
         resp_i = 1'b1; burst_i = rand64();
         tick();
      end
      rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
      tick();
      chk("rstmid_read_o_drop", 256'(read_o), 256'(1'b0));
      chk("rstmid_resp_o", 256'(resp_o), 256'(1'b0));
      chk("rstmid_line_o", line_o, 256'(0));
      rst = 1'b0;
      model_line = '0;
      idle_cycles(1);
      for (int k = 0; k < 4; k++) b[k] = rand64();
      g = '{0, 0, 0, 0};
      do_read(32'h0BAD_F00D, b, g, 1'b0);

      // back-to-back: write raised right after the read's completion pulse
      wl = rand256();
      g = '{1, 0, 0, 0};
      do_write(32'h0000_0100, wl, g);
      for (int k = 0; k < 4; k++) b[k] = rand64();
      g = '{0, 0, 1, 0};
      do_read(32'h0000_0200, b, g, 1'b0);
      idle_cycles(1);

      // randomized traffic
      for (int t = 0; t < 12; t++) begin
         for (int k = 0; k < 4; k++) g[k] = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k < 4; k++) b[k] = rand64();
            do_read($urandom(), b, g, 1'($urandom()));
         end else begin
            do_write($urandom(), rand256(), g);
         end
         idle_cycles($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
